trap_ctrl: RTL and testbench

- Commit-side trap/interrupt controller; sits directly upstream of the CSR file.
- Watches the committing instruction, the external interrupt lines and the current CSR state.
- Decides when a trap, ecall or mret is taken, and emits a one-cycle trap record (pc, code, kind) to the CSR writer path.
- Emits a pipeline flush and a PC redirect to the trap vector or mepc, then holds commit while the CSR file settles.

---
 rtl/csr_pkg.sv | 32 +++
 rtl/trap_ctrl_irq_prio.sv | 24 ++
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR/trap definitions: trap FSM states, cause codes, mstatus bit
// positions and the trap record handed to the CSR writer.
package csr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAKE   = 2'd1,
    SETTLE = 2'd2
  } trap_state_t;

  localparam logic [5:0] EXC_ECALL_M = 6'd8;
  localparam logic [5:0] IRQ_MSI     = 6'd3;
  localparam logic [5:0] IRQ_MTI     = 6'd7;
  localparam logic [5:0] IRQ_MEI     = 6'd11;

  localparam int unsigned MSTATUS_MIE_BIT = 3;

  // Machine-level interrupt bits this controller arbitrates.
  localparam logic [63:0] IRQ_M_MASK = 64'h0000_0000_0000_0888;

  typedef struct packed {
    logic       trap_valid;
    logic       is_exception;
    logic [5:0] trap_code;
  } trap_rec_t;

  // Direct-mode trap base from the upper mtvec bits.
  function automatic logic [63:0] trap_base(input logic [61:0] base_hi);
    return {base_hi, 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// irq_prio: fixed-priority machine interrupt arbiter, MEI > MSI > MTI.
// Purely combinational; bits outside the three machine causes are ignored.
module irq_prio
  import csr_pkg::*;
(
  input  logic [63:0] pend,
  output logic        any,
  output logic [5:0]  code
);

  // Pick the highest-priority pending machine interrupt.
  always_comb begin
    any  = |(pend & IRQ_M_MASK);
    code = '0;
    if (pend[IRQ_MEI]) begin
      code = IRQ_MEI;
    end else if (pend[IRQ_MSI]) begin
      code = IRQ_MSI;
    end else if (pend[IRQ_MTI]) begin
      code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-side trap/interrupt controller feeding the CSR file.
// Decides interrupt/exception/ecall/mret at commit, pulses a trap record,
// flush and redirect for one cycle, then stalls commit for SETTLE_CYCLES.
// Optional macro TRAP_VECTORED_EN: vectored interrupt targets when
// mtvec[1:0] == 2'b01.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [63:0] RESET_PC      = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        commit_exc,
  input  logic [5:0]  commit_exc_code,
  input  logic        commit_ecall,
  input  logic        commit_mret,
  output logic        commit_ready,
  input  logic        irq_mtip,
  input  logic        irq_msip,
  input  logic        irq_meip,
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic [63:0] mip,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  input  logic [1:0]  pmode,
  output logic        trap_valid,
  output logic        trap_is_exception,
  output logic [5:0]  trap_code,
  output logic        trap_ecall,
  output logic        trap_mret,
  output logic [63:0] trap_pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  localparam logic [1:0] CNT_INIT = 2'(SETTLE_CYCLES - 1);

  trap_state_t state;
  logic [1:0]  cnt;

  logic [63:0] irq_lines;
  logic [63:0] pend;
  logic        gie;
  logic        irq_any;
  logic [5:0]  irq_code;

  trap_rec_t   rec_d;
  trap_rec_t   rec_q;
  logic        ecall_d;
  logic        mret_d;
  logic [63:0] rpc_d;
  logic        take;

  logic        unused_bits;

  // Fold the external level lines into their mip positions.
  always_comb begin
    irq_lines          = '0;
    irq_lines[IRQ_MEI] = irq_meip;
    irq_lines[IRQ_MTI] = irq_mtip;
    irq_lines[IRQ_MSI] = irq_msip;
  end

  assign pend = (mip | irq_lines) & mie;
  assign gie  = (pmode == 2'b00) | mstatus[MSTATUS_MIE_BIT];

  irq_prio u_irq_prio (
    .pend (pend),
    .any  (irq_any),
    .code (irq_code)
  );

  // Commit decision: interrupt > exception > ecall > mret.
  always_comb begin
    rec_d   = '0;
    ecall_d = 1'b0;
    mret_d  = 1'b0;
    rpc_d   = trap_base(mtvec[63:2]);
    if (gie && irq_any) begin
      rec_d = '{trap_valid: 1'b1, is_exception: 1'b0, trap_code: irq_code};
`ifdef TRAP_VECTORED_EN
      if (mtvec[1:0] == 2'b01) begin
        rpc_d = trap_base(mtvec[63:2]) + {56'd0, irq_code, 2'b00};
      end
`endif
    end else if (commit_exc) begin
      rec_d = '{trap_valid: 1'b1, is_exception: 1'b1, trap_code: commit_exc_code};
    end else if (commit_ecall) begin
      rec_d   = '{trap_valid: 1'b1, is_exception: 1'b1, trap_code: EXC_ECALL_M};
      ecall_d = 1'b1;
    end else if (commit_mret) begin
      mret_d = 1'b1;
      rpc_d  = mepc;
    end
    take = commit_valid && (state == IDLE) && (rec_d.trap_valid || mret_d);
  end

  // Bits of the CSR inputs this block never consults.
`ifdef TRAP_VECTORED_EN
  assign unused_bits = ^{mstatus[63:4], mstatus[2:0]};
`else
  assign unused_bits = ^{mstatus[63:4], mstatus[2:0], mtvec[1:0]};
`endif

  // Trap sequencing: IDLE -> TAKE -> SETTLE (SETTLE_CYCLES) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) state <= TAKE;
        end
        TAKE: begin
          state <= SETTLE;
          cnt   <= CNT_INIT;
        end
        SETTLE: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered trap record and one-cycle flush/redirect pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q          <= '0;
      trap_ecall     <= 1'b0;
      trap_mret      <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      trap_pc        <= '0;
      redirect_pc    <= RESET_PC;
    end else begin
      rec_q.trap_valid <= 1'b0;
      trap_ecall       <= 1'b0;
      trap_mret        <= 1'b0;
      flush            <= 1'b0;
      redirect_valid   <= 1'b0;
      if (take) begin
        rec_q          <= rec_d;
        trap_ecall     <= ecall_d;
        trap_mret      <= mret_d;
        flush          <= 1'b1;
        redirect_valid <= 1'b1;
        trap_pc        <= commit_pc;
        redirect_pc    <= rpc_d;
      end
    end
  end

  assign trap_valid        = rec_q.trap_valid;
  assign trap_is_exception = rec_q.is_exception;
  assign trap_code         = rec_q.trap_code;
  assign commit_ready      = (state == IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: each commit pushes its expected trap
// record; the record is popped and compared on the following cycle.
module tb_trap_ctrl;

  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_exc;
  logic [5:0]  commit_exc_code;
  logic        commit_ecall;
  logic        commit_mret;
  logic        commit_ready;
  logic        irq_mtip, irq_msip, irq_meip;
  logic [63:0] mstatus, mie, mip, mtvec, mepc;
  logic [1:0]  pmode;
  logic        trap_valid, trap_is_exception, trap_ecall, trap_mret;
  logic [5:0]  trap_code;
  logic [63:0] trap_pc;
  logic        flush, redirect_valid;
  logic [63:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        take;
    logic        trap;
    logic        is_exc;
    logic [5:0]  code;
    logic        ecall;
    logic        mret;
    logic [63:0] pc;
    logic [63:0] rpc;
  } exp_t;

  exp_t exp_q[$];

  trap_ctrl #(.SETTLE_CYCLES(SETTLE), .RESET_PC(64'h8000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .commit_valid      (commit_valid),
    .commit_pc         (commit_pc),
    .commit_exc        (commit_exc),
    .commit_exc_code   (commit_exc_code),
    .commit_ecall      (commit_ecall),
    .commit_mret       (commit_mret),
    .commit_ready      (commit_ready),
    .irq_mtip          (irq_mtip),
    .irq_msip          (irq_msip),
    .irq_meip          (irq_meip),
    .mstatus           (mstatus),
    .mie               (mie),
    .mip               (mip),
    .mtvec             (mtvec),
    .mepc              (mepc),
    .pmode             (pmode),
    .trap_valid        (trap_valid),
    .trap_is_exception (trap_is_exception),
    .trap_code         (trap_code),
    .trap_ecall        (trap_ecall),
    .trap_mret         (trap_mret),
    .trap_pc           (trap_pc),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic exp_t mk(input logic take, input logic trap, input logic is_exc,
                              input logic [5:0] code, input logic ecall, input logic mret,
                              input logic [63:0] pc, input logic [63:0] rpc);
    exp_t e;
    e.take = take; e.trap = trap; e.is_exc = is_exc; e.code = code;
    e.ecall = ecall; e.mret = mret; e.pc = pc; e.rpc = rpc;
    return e;
  endfunction

  task automatic clear_commit();
    commit_valid = 1'b0; commit_exc = 1'b0; commit_exc_code = '0;
    commit_ecall = 1'b0; commit_mret = 1'b0;
  endtask

  // Drive one commit, then compare the popped expectation and the stall window.
  // hold keeps commit_valid asserted through TAKE/SETTLE.
  task automatic do_commit(input string tag, input logic [63:0] pc, input logic exc,
                           input logic [5:0] code, input logic ecall, input logic mret,
                           input logic hold, input exp_t e);
    exp_t got;
    @(negedge clk);
    check({tag, ".ready_pre"}, 64'(commit_ready), 64'd1);
    commit_valid = 1'b1; commit_pc = pc; commit_exc = exc; commit_exc_code = code;
    commit_ecall = ecall; commit_mret = mret;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) clear_commit();
    check({tag, ".q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    got = exp_q.pop_front();
    check({tag, ".trap_valid"}, 64'(trap_valid), 64'(got.trap));
    check({tag, ".trap_mret"}, 64'(trap_mret), 64'(got.mret));
    check({tag, ".trap_ecall"}, 64'(trap_ecall), 64'(got.ecall));
    check({tag, ".flush"}, 64'(flush), 64'(got.take));
    check({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(got.take));
    if (got.trap) begin
      check({tag, ".is_exc"}, 64'(trap_is_exception), 64'(got.is_exc));
      check({tag, ".code"}, 64'(trap_code), 64'(got.code));
      check({tag, ".trap_pc"}, trap_pc, got.pc);
    end
    if (got.take) begin
      check({tag, ".redirect_pc"}, redirect_pc, got.rpc);
      check({tag, ".ready_take"}, 64'(commit_ready), 64'd0);
      for (int s = 0; s < SETTLE; s++) begin
        @(posedge clk); #1;
        check({tag, ".ready_settle"}, 64'(commit_ready), 64'd0);
        check({tag, ".no_pulse_settle"}, 64'(trap_valid | flush | redirect_valid), 64'd0);
      end
      clear_commit();
      @(posedge clk); #1;
      check({tag, ".ready_after"}, 64'(commit_ready), 64'd1);
      check({tag, ".no_pulse_after"}, 64'(trap_valid | flush | trap_mret), 64'd0);
    end else begin
      clear_commit();
      check({tag, ".ready_idle"}, 64'(commit_ready), 64'd1);
    end
  endtask

  task automatic set_csr(input logic [63:0] st, input logic [63:0] ie, input logic [63:0] ip,
                         input logic [1:0] pm, input logic meip, input logic mtip, input logic msip);
    mstatus = st; mie = ie; mip = ip; pmode = pm;
    irq_meip = meip; irq_mtip = mtip; irq_msip = msip;
  endtask

  localparam logic [63:0] BASE = 64'h8000_0400;

  initial begin
    logic [63:0] vec_rpc;
    rst = 1'b1;
    clear_commit();
    commit_pc = '0;
    mtvec = BASE; mepc = '0;
    set_csr(64'h0, 64'h0, 64'h0, 2'd3, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("rst.commit_ready", 64'(commit_ready), 64'd1);
    check("rst.pulses", 64'({trap_valid, trap_ecall, trap_mret, flush, redirect_valid}), 64'd0);
    check("rst.trap_code", 64'(trap_code), 64'd0);
    check("rst.trap_pc", trap_pc, 64'd0);
    check("rst.redirect_pc", redirect_pc, 64'h8000_0000);
    rst = 1'b0;

    // ecall to the trap base
    do_commit("ecall", 64'h8000_0100, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0,
              mk(1, 1, 1, 6'd8, 1, 0, 64'h8000_0100, BASE));
    // mret back to mepc
    mepc = 64'h8000_0104;
    do_commit("mret", 64'h8000_0500, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
              mk(1, 0, 0, 6'd0, 0, 1, 64'h0, 64'h8000_0104));
    // timer interrupt with global enable from mstatus.MIE
    set_csr(64'h8, 64'h80, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0);
    do_commit("mti", 64'h8000_0200, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 0, 6'd7, 0, 0, 64'h8000_0200, BASE));
    set_csr(64'h0, 64'h80, 64'h0, 2'd3, 1'b0, 1'b1, 1'b0);
    do_commit("mti_masked", 64'h8000_0200, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
              mk(0, 0, 0, 6'd0, 0, 0, 64'h0, 64'h0));
    set_csr(64'h0, 64'h80, 64'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    do_commit("mti_umode", 64'h8000_0200, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 0, 6'd7, 0, 0, 64'h8000_0200, BASE));
    // all lines high: MEI wins; vectored target when enabled
    mtvec = 64'h8000_0401;
`ifdef TRAP_VECTORED_EN
    vec_rpc = 64'h8000_042C;
`else
    vec_rpc = BASE;
`endif
    set_csr(64'h8, 64'h888, 64'h0, 2'd3, 1'b1, 1'b1, 1'b1);
    do_commit("mei_all", 64'h8000_0300, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 0, 6'd11, 0, 0, 64'h8000_0300, vec_rpc));
    // exceptions always go to the base even with vectored mode
    set_csr(64'h8, 64'h0, 64'h0, 2'd3, 1'b0, 1'b0, 1'b0);
    do_commit("exc_vec", 64'h8000_0310, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 1, 6'd5, 0, 0, 64'h8000_0310, BASE));
    // mtvec mode 2 treated as direct; MSI beats MTI
    mtvec = 64'h8000_0402;
    set_csr(64'h8, 64'h88, 64'h0, 2'd3, 1'b0, 1'b1, 1'b1);
    do_commit("msi_direct", 64'h8000_0320, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 0, 6'd3, 0, 0, 64'h8000_0320, BASE));
    mtvec = BASE;
    // pending from mip beats a simultaneous exception
    set_csr(64'h8, 64'h8, 64'h8, 2'd3, 1'b0, 1'b0, 1'b0);
    do_commit("mip_over_exc", 64'h8000_0330, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0,
              mk(1, 1, 0, 6'd3, 0, 0, 64'h8000_0330, BASE));
    // exc beats ecall; commit_valid held through the stall window
    set_csr(64'h8, 64'h0, 64'h0, 2'd3, 1'b0, 1'b0, 1'b0);
    do_commit("exc_ecall_hold", 64'h8000_0340, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1,
              mk(1, 1, 1, 6'd2, 0, 0, 64'h8000_0340, BASE));
    // exc beats mret
    mepc = 64'h8000_0999;
    do_commit("exc_mret", 64'h8000_0350, 1'b1, 6'd13, 1'b0, 1'b1, 1'b0,
              mk(1, 1, 1, 6'd13, 0, 0, 64'h8000_0350, BASE));

    // reset during TAKE drops pulses at once
    @(negedge clk);
    commit_valid = 1'b1; commit_pc = 64'h8000_0360; commit_ecall = 1'b1;
    @(posedge clk); #1;
    clear_commit();
    check("rstmid.trap_valid_pre", 64'(trap_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rstmid.pulses", 64'({trap_valid, flush, redirect_valid}), 64'd0);
    check("rstmid.redirect_pc", redirect_pc, 64'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid.ready_after", 64'(commit_ready), 64'd1);
    check("rstmid.no_trap_after", 64'(trap_valid), 64'd0);

    check("scoreboard.drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
